// File: rtl/wm_pkg.sv
// wm_pkg -- shared definitions for the watermark embed/serialize slice.
//   - Mode encoding applied to the K LSB planes (replace or xor).
//   - FSM state type and state constants for the serializer.
//   - Default geometry (pixel width, channels per group, LSB planes).
package wm_pkg;

  // Embedding mode, sampled together with the pixel group.
  localparam logic [0:0] WM_REPLACE = 1'b0;
  localparam logic [0:0] WM_XOR     = 1'b1;

  // Serializer FSM state type and its encodings.
  typedef logic [0:0] wm_state_t;
  localparam wm_state_t ST_IDLE  = 1'b0;
  localparam wm_state_t ST_SHIFT = 1'b1;

  // Default geometry.
  localparam int WM_PIX_W_DEF = 8;
  localparam int WM_NCH_DEF   = 4;
  localparam int WM_K_DEF     = 1;

endpackage : wm_pkg

// File: rtl/wm_lsb_embed.sv
// wm_lsb_embed -- combinational embedding of K watermark bits into the
// low planes of one pixel channel.
// Ports:
//   pix    in  PIX_W  original channel value
//   wm     in  K      watermark bits for this channel
//   mode   in  1      WM_REPLACE: overwrite LSBs, WM_XOR: xor into LSBs
//   bypass in  1      1 = pass pix through untouched
//   emb    out PIX_W  embedded channel value
module wm_lsb_embed
  import wm_pkg::*;
#(
  parameter int PIX_W = WM_PIX_W_DEF,
  parameter int K     = WM_K_DEF
) (
  input  logic [PIX_W-1:0] pix,
  input  logic [K-1:0]     wm,
  input  logic             mode,
  input  logic             bypass,
  output logic [PIX_W-1:0] emb
);

  // Mask of the K low planes; built by shifting so K == PIX_W needs no
  // zero-width slice.
  localparam logic [PIX_W-1:0] LSB_MASK = {PIX_W{1'b1}} >> (PIX_W - K);

  logic [PIX_W-1:0] wm_ext_s;

  assign wm_ext_s = PIX_W'(wm);

  // Select the embedded value for this channel.
  always_comb begin
    emb = pix;
    if (bypass) begin
      emb = pix;
    end else begin
      case (mode)
        WM_REPLACE: emb = (pix & ~LSB_MASK) | wm_ext_s;
        WM_XOR:     emb = pix ^ wm_ext_s;
        default:    emb = pix;
      endcase
    end
  end

endmodule : wm_lsb_embed

// File: rtl/wm_embed_serializer.sv
// wm_embed_serializer -- embeds a watermark into a group of NCH pixel
// channels and streams the result out one bit per handshake, channel 0
// first and MSB-first within each channel.
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   in_valid/in_ready    group input handshake (in_data, wm_bits, mode,
//                        bypass are only looked at in the accept cycle)
//   out_bit/out_valid    serial output with valid/ready flow control
//   out_ready
//   out_last             marks the final bit of a group
//   grp_cnt              number of fully transmitted groups (wraps)
module wm_embed_serializer
  import wm_pkg::*;
#(
  parameter int PIX_W = WM_PIX_W_DEF,
  parameter int NCH   = WM_NCH_DEF,
  parameter int K     = WM_K_DEF,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NCH*PIX_W-1:0] in_data,
  input  logic [NCH*K-1:0]   wm_bits,
  input  logic               mode,
  input  logic               bypass,
  output logic               out_bit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic [CNT_W-1:0]   grp_cnt
);

  localparam int DW   = NCH * PIX_W;
  localparam int BC_W = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [BC_W-1:0] BC_TOP = BC_W'(DW - 1);

  if ((K < 1) || (K > PIX_W)) begin : g_bad_k
    $error("wm_embed_serializer: K must be in 1..PIX_W");
  end

  wm_state_t          state_r;
  logic [DW-1:0]      shift_r;
  logic [BC_W-1:0]    bcnt_r;
  logic [CNT_W-1:0]   grp_cnt_r;
  logic [DW-1:0]      load_s;
  logic               last_s;
  logic               in_ready_s;
  logic               accept_s;

  // Channel 0 lands in the top slice so a left shift emits it first.
  for (genvar i = 0; i < NCH; i++) begin : g_emb
    logic [PIX_W-1:0] emb_s;
    wm_lsb_embed #(
      .PIX_W (PIX_W),
      .K     (K)
    ) u_emb (
      .pix    (in_data[i*PIX_W +: PIX_W]),
      .wm     (wm_bits[i*K +: K]),
      .mode   (mode),
      .bypass (bypass),
      .emb    (emb_s)
    );
    assign load_s[(NCH-1-i)*PIX_W +: PIX_W] = emb_s;
  end

  // Last-bit detect and input acceptance; during the last bit a new group
  // may be taken only if the final bit is leaving in the same cycle.
  always_comb begin
    last_s     = 1'b0;
    in_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        last_s     = 1'b0;
        in_ready_s = 1'b1;
      end
      ST_SHIFT: begin
        last_s     = (bcnt_r == {BC_W{1'b0}});
        in_ready_s = last_s & out_ready;
      end
      default: begin
        last_s     = 1'b0;
        in_ready_s = 1'b0;
      end
    endcase
  end

  assign accept_s  = in_valid & in_ready_s;
  assign in_ready  = in_ready_s;
  assign out_valid = (state_r == ST_SHIFT);
  assign out_bit   = shift_r[DW-1];
  assign out_last  = last_s;
  assign grp_cnt   = grp_cnt_r;

  // FSM, shift register, bit counter and group counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      shift_r   <= {DW{1'b0}};
      bcnt_r    <= {BC_W{1'b0}};
      grp_cnt_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            shift_r <= load_s;
            bcnt_r  <= BC_TOP;
            state_r <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (out_ready) begin
            if (last_s) begin
              grp_cnt_r <= grp_cnt_r + CNT_W'(1'b1);
              if (accept_s) begin
                // Back-to-back group: reload with no idle cycle.
                shift_r <= load_s;
                bcnt_r  <= BC_TOP;
              end else begin
                // Shifting out the final bit leaves the register all zero.
                shift_r <= shift_r << 1;
                state_r <= ST_IDLE;
              end
            end else begin
              shift_r <= shift_r << 1;
              bcnt_r  <= bcnt_r - BC_W'(1'b1);
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : wm_embed_serializer

// File: tb/tb_wm_embed_serializer.sv
// Scoreboard bench for wm_embed_serializer: each accepted group is
// expanded by a reference model into its expected bit stream; a negedge
// monitor compares every presented bit, flow-control output and counter.
module tb_wm_embed_serializer;

  localparam int PIX_W = 8;
  localparam int NCH   = 4;
  localparam int K     = 1;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [NCH*PIX_W-1:0] in_data = '0;
  logic [NCH*K-1:0]     wm_bits = '0;
  logic                 mode = 1'b0;
  logic                 bypass = 1'b0;
  logic                 out_bit;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 out_last;
  logic [CNT_W-1:0]     grp_cnt;

  int          total = 0;
  int          bad = 0;
  exp_t        q[$];
  logic [15:0] exp_grp = 16'd0;
  logic [31:0] coll = 32'd0;
  logic [31:0] last_word = 32'd0;
  int          words_done = 0;
  int          hs_total = 0;
  int          ready_mode = 0;

  wm_embed_serializer #(
    .PIX_W (PIX_W),
    .NCH   (NCH),
    .K     (K),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .wm_bits   (wm_bits),
    .mode      (mode),
    .bypass    (bypass),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .grp_cnt   (grp_cnt)
  );

  always #5 clk = ~clk;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
    end
  endfunction

  // Reference model: embed each channel from the arithmetic rules and
  // append its bits, channel 0 first, MSB first.
  function automatic void push_group(logic [31:0] d, logic [3:0] w, logic m, logic bp);
    int   pix;
    int   wi;
    int   e;
    exp_t x;
    for (int i = 0; i < NCH; i++) begin
      pix = int'(d >> (i * PIX_W)) & ((1 << PIX_W) - 1);
      wi  = int'(w >> (i * K)) & ((1 << K) - 1);
      if (bp)      e = pix;
      else if (!m) e = (pix & ~((1 << K) - 1)) | wi;
      else         e = pix ^ wi;
      for (int b = PIX_W - 1; b >= 0; b--) begin
        x.b    = e[b];
        x.last = (i == NCH - 1) && (b == 0);
        q.push_back(x);
      end
    end
  endfunction

  // Monitor: compare outputs against the scoreboard, then record accepts.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_bit", 64'(out_bit), 64'd0);
      check("rst_out_last", 64'(out_last), 64'd0);
      check("rst_grp_cnt", 64'(grp_cnt), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      q.delete();
      exp_grp = 16'd0;
      coll    = 32'd0;
    end else begin
      check("grp_cnt", 64'(grp_cnt), 64'(exp_grp));
      check("out_valid", 64'(out_valid), 64'(q.size() > 0));
      check("in_ready", 64'(in_ready),
            64'((q.size() == 0) || (q[0].last && out_ready)));
      if (out_valid && (q.size() > 0)) begin
        check("out_bit", 64'(out_bit), 64'(q[0].b));
        check("out_last", 64'(out_last), 64'(q[0].last));
        if (out_ready) begin
          coll = {coll[30:0], out_bit};
          hs_total++;
          if (q[0].last) begin
            exp_grp    = exp_grp + 16'd1;
            last_word  = coll;
            words_done++;
          end
          void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        push_group(in_data, wm_bits, mode, bypass);
      end
    end
  end

  // Sink ready pattern: 0 = always ready, 1 = toggle, 2 = random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Offer one group and hold it until accepted; scramble the inputs after.
  task automatic send_group(input logic [31:0] d, input logic [3:0] w,
                            input logic m, input logic bp);
    int budget = 0;
    bit ok = 1'b0;
    in_data  = d;
    wm_bits  = w;
    mode     = m;
    bypass   = bp;
    in_valid = 1'b1;
    while (!ok && budget < 500) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    in_data = $urandom;
    wm_bits = 4'($urandom);
    mode    = 1'($urandom);
    bypass  = 1'($urandom);
  endtask

  task automatic wait_words(input int target, input int limit);
    int n = 0;
    while (words_done < target && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (words_done < target) check("group_timeout", 64'(words_done), 64'(target));
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string nm, input logic [31:0] d, input logic [3:0] w,
                          input logic m, input logic bp, input logic [31:0] word);
    int base = words_done;
    send_group(d, w, m, bp);
    in_valid = 1'b0;
    wait_words(base + 1, 2000);
    check(nm, 64'(last_word), 64'(word));
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int nb;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    directed("replace_1111", 32'h02200880, 4'b1111, 1'b0, 1'b0, 32'h81092103);
    check("grp_cnt_first", 64'(grp_cnt), 64'd1);
    directed("xor_0101", 32'hAA6B726A, 4'b0101, 1'b1, 1'b0, 32'h6B726AAA);
    directed("replace_0101", 32'hAA6B726A, 4'b0101, 1'b0, 1'b0, 32'h6B726BAA);
    directed("bypass", 32'h03300CC0, 4'($urandom), 1'($urandom), 1'b1, 32'hC00C3003);

    // Stalled sink: alternating ready over a whole group.
    ready_mode = 1;
    directed("toggle_ready", 32'h02200880, 4'b1111, 1'b0, 1'b0, 32'h81092103);
    ready_mode = 0;

    // Two groups with in_valid held high: contiguous output.
    base = words_done;
    send_group(32'hAA6B726A, 4'b0101, 1'b1, 1'b0);
    send_group(32'h02200880, 4'b1111, 1'b0, 1'b0);
    in_valid = 1'b0;
    wait_words(base + 2, 2000);
    check("b2b_second_word", 64'(last_word), 64'h81092103);

    // Reset after ten bits of a group.
    base = hs_total;
    send_group(32'($urandom), 4'($urandom), 1'b0, 1'b0);
    in_valid = 1'b0;
    nb = 0;
    while (hs_total < base + 10 && nb < 200) begin
      @(negedge clk);
      #1;
      nb++;
    end
    check("bits_before_rst", 64'(hs_total - base), 64'd10);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_bit", 64'(out_bit), 64'd0);
    check("async_rst_last", 64'(out_last), 64'd0);
    check("async_rst_grp", 64'(grp_cnt), 64'd0);
    check("async_rst_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    directed("after_rst", 32'hAA6B726A, 4'b0101, 1'b1, 1'b0, 32'h6B726AAA);
    check("grp_after_rst", 64'(grp_cnt), 64'd1);

    // Random groups, random gaps, random sink stalls.
    ready_mode = 2;
    base = words_done;
    for (int g = 0; g < 30; g++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      send_group($urandom, 4'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end
    in_valid = 1'b0;
    wait_words(base + 30, 20000);
    check("grp_cnt_random", 64'(grp_cnt), 64'd31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_wm_embed_serializer

// File: doc/wm_embed_serializer.md
WM_EMBED_SERIALIZER -- requirements
Module: wm_embed_serializer

Interface
REQ-001 SHALL have parameter PIX_W, default 8, meaning bits per pixel channel.
REQ-002 SHALL have parameter NCH, default 4, meaning pixel channels per group.
REQ-003 SHALL have parameter K, default 1, meaning watermark bits embedded per channel (LSB planes); legal 1..PIX_W.
REQ-004 SHALL have parameter CNT_W, default 16, meaning width of the group counter.
REQ-005 SHALL have the following ports, listed as name, direction, width, meaning:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous and active-high.
- in_valid  in  1  input group valid.
- in_ready  out  1  input group accepted when in_valid and in_ready are both high.
- in_data  in  NCH*PIX_W  pixels; channel i occupies bits [i*PIX_W +: PIX_W].
- wm_bits  in  NCH*K  watermark; channel i uses bits [i*K +: K].
- mode  in  1  0 = REPLACE the K LSBs, 1 = XOR into the K LSBs; sampled at accept.
- bypass  in  1  1 = pass pixels unmodified; sampled at accept.
- out_bit  out  1  serial watermarked data.
- out_valid  out  1  out_bit valid.
- out_ready  in  1  sink accepts out_bit when out_valid and out_ready are both high.
- out_last  out  1  high with the final bit of a group.
- grp_cnt  out  CNT_W  count of completed groups.

Function
REQ-006 SHALL compute each embedded channel at accept as follows.
- REPLACE: {pix[PIX_W-1:K], wm_i}.
- XOR: {pix[PIX_W-1:K], pix[K-1:0] ^ wm_i}.
- bypass=1: pix unchanged, regardless of mode.
REQ-007 SHALL use an FSM with the states IDLE and SHIFT.
- IDLE: in_ready=1, out_valid=0.
- SHIFT: in_ready=0 except as in REQ-010; out_valid=1.
REQ-008 SHALL handle accept in IDLE as follows.
- Load all NCH embedded channels into a NCH*PIX_W shift register.
- Load bit counter = NCH*PIX_W-1.
- Enter SHIFT on the next cycle.
- First out_bit is presented in the cycle after accept (latency 1).
REQ-009 SHALL serialize channel 0 first and MSB-first within each channel.
- Shift and decrement only on an out_valid&out_ready handshake.
- out_bit, out_last and the shift register SHALL hold stable while out_ready=0.
REQ-010 SHALL drive out_last=1 when counter==0; in that cycle in_ready SHALL equal out_ready.
- Last-bit handshake with simultaneous input accept: reload and remain in SHIFT, zero bubble.
- Last-bit handshake without accept: return to IDLE.
REQ-011 SHALL increment grp_cnt by 1 on each last-bit handshake, wrapping from 2^CNT_W-1 to 0.
REQ-012 SHALL ignore in_data, wm_bits, mode and bypass except in the accept cycle.
REQ-013 SHALL reject illegal K (0 or >PIX_W) at elaboration.

Reset
REQ-014 SHALL, on rst assertion at any time including mid-group, immediately clear the following.
- FSM to IDLE.
- Shift register and counter to 0.
- out_bit=0, out_valid=0, out_last=0, grp_cnt=0, in_ready=1.
REQ-015 SHALL discard a partially sent group on reset, with no resumption, and SHALL NOT count it.

Structure
REQ-016 SHALL place the following in shared package wm_pkg.
- The mode encoding constants (WM_REPLACE=0, WM_XOR=1).
- The FSM state typedef.
- The default PIX_W/NCH/K values.
REQ-017 SHALL implement per-channel embedding in sub-module wm_lsb_embed, which is combinational and instantiated NCH times.

Verification
REQ-018 SHALL cover each of the following directed scenarios.
- REPLACE, wm_bits=4'b1111, in_data channels {0x80,0x08,0x20,0x02} -> 32 serial bits equal to 0x81,0x09,0x21,0x03 MSB-first ch0 first; out_last on bit 32; grp_cnt=1.
- XOR, wm_bits=4'b0101, channels {0x6A,0x72,0x6B,0xAA} -> 0x6B,0x72,0x6A,0xAA.
- REPLACE, same wm and pixels as the XOR case -> 0x6B,0x72,0x6B,0xAA.
- bypass=1 with channels {0xC0,0x0C,0x30,0x03}, any wm -> same values out.
- out_ready toggled 1010... over a group -> identical bit sequence; out_bit stable while stalled.
- Two groups with in_valid held high -> 64 contiguous bits, no idle cycle.
- rst pulsed after bit 10 -> outputs zero at once; next group starts at its ch0 MSB; grp_cnt counts only complete groups.
